// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game: FSM states, score width,
// button polarity, level targets and the saturating score increment.
package game_pkg;

  localparam int SCORE_W             = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int SYNC_STAGES_DEF     = 2;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  localparam logic [SCORE_W-1:0] LEVEL_EASY = 5'd10;
  localparam logic [SCORE_W-1:0] LEVEL_MID  = 5'd15;
  localparam logic [SCORE_W-1:0] LEVEL_HARD = 5'd20;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } game_state_e;

  // Score increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == {SCORE_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(SCORE_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/hit_scorer_if.sv
// Player-side bus of the hit scorer: button, target, countdown overflow in;
// score, strobe and game-result levels out.
interface hit_scorer_if;
  import game_pkg::*;

  logic               btn_n;
  logic [SCORE_W-1:0] target;
  logic               time_up;
  logic [SCORE_W-1:0] score;
  logic               hit_pulse;
  logic               win;
  logic               lose;
  logic               playing;

  modport master (
    output btn_n, target, time_up,
    input  score, hit_pulse, win, lose, playing
  );

  modport slave (
    input  btn_n, target, time_up,
    output score, hit_pulse, win, lose, playing
  );

endinterface

// File: rtl/btn_debounce.sv
// Button front end: synchroniser, hold-time debounce and a one-cycle pulse on
// each accepted released->pressed transition.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed_pulse
);

  localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   bs_s;
  logic                   stable_r;
  logic [31:0]            cnt_r;
  logic                   pulse_r;

  assign bs_s          = sync_r[SYNC_STAGES-1];
  assign pressed_pulse = pulse_r;

  // Synchroniser chain, reset to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{BTN_RELEASED}};
    end else begin
      sync_r[0] <= btn_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // A new level must differ for DEBOUNCE_CYCLES consecutive cycles; the
  // counter stops at CNT_LAST so it can never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_r <= BTN_RELEASED;
      cnt_r    <= 32'd0;
      pulse_r  <= 1'b0;
    end else if (bs_s == stable_r) begin
      cnt_r    <= 32'd0;
      pulse_r  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      stable_r <= bs_s;
      cnt_r    <= 32'd0;
      pulse_r  <= (bs_s == BTN_PRESSED);
    end else begin
      cnt_r    <= cnt_r + 32'd1;
      pulse_r  <= 1'b0;
    end
  end

endmodule

// File: rtl/hit_scorer.sv
// Scores debounced button presses against the selected target and resolves
// the game to WIN or LOSE when the countdown overflows.
module hit_scorer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  hit_scorer_if.slave   bus
);

  game_state_e            state_r;
  logic [SCORE_W-1:0]     score_r;
  logic [SCORE_W-1:0]     next_score_s;
  logic                   hit_pulse_r;
  logic                   win_r;
  logic                   lose_r;
  logic                   playing_r;
  logic                   press_s;
  logic [SYNC_STAGES-1:0] ts_sync_r;
  logic                   ts_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (bus.btn_n),
    .pressed_pulse (press_s)
  );

  assign ts_s          = ts_sync_r[SYNC_STAGES-1];
  assign bus.score     = score_r;
  assign bus.hit_pulse = hit_pulse_r;
  assign bus.win       = win_r;
  assign bus.lose      = lose_r;
  assign bus.playing   = playing_r;

  // time_up synchroniser from the slow countdown domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ts_sync_r[0] <= bus.time_up;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ts_sync_r[i] <= ts_sync_r[i-1];
      end
    end
  end

  // Score the would-be next value so a winning press beats a same-cycle timeout.
  always_comb begin
    next_score_s = score_r;
    if (press_s) begin
      next_score_s = sat_inc(score_r);
    end else begin
      next_score_s = score_r;
    end
  end

  // Game FSM with registered score and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= PLAY;
      score_r     <= {SCORE_W{1'b0}};
      hit_pulse_r <= 1'b0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
      playing_r   <= 1'b1;
    end else begin
      case (state_r)
        PLAY: begin
          hit_pulse_r <= press_s;
          score_r     <= next_score_s;
          if (next_score_s >= bus.target) begin
            state_r   <= WIN;
            win_r     <= 1'b1;
            lose_r    <= 1'b0;
            playing_r <= 1'b0;
          end else if (ts_s) begin
            state_r   <= LOSE;
            win_r     <= 1'b0;
            lose_r    <= 1'b1;
            playing_r <= 1'b0;
          end else begin
            state_r   <= PLAY;
            win_r     <= 1'b0;
            lose_r    <= 1'b0;
            playing_r <= 1'b1;
          end
        end
        WIN: begin
          hit_pulse_r <= 1'b0;
          win_r       <= 1'b1;
          lose_r      <= 1'b0;
          playing_r   <= 1'b0;
        end
        LOSE: begin
          hit_pulse_r <= 1'b0;
          win_r       <= 1'b0;
          lose_r      <= 1'b1;
          playing_r   <= 1'b0;
        end
        default: begin
          // Unreachable encoding: fall back to a frozen loss, never a false win.
          state_r     <= LOSE;
          hit_pulse_r <= 1'b0;
          win_r       <= 1'b0;
          lose_r      <= 1'b1;
          playing_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_hit_scorer;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   p0;
  logic last_pulse_win = 1'b0;
  logic [31:0] last_pulse_score = 32'd0;

  hit_scorer_if bus ();

  hit_scorer #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count accepted presses and capture the result levels seen alongside each.
  always @(negedge clk) begin
    if (bus.hit_pulse === 1'b1) begin
      pulses           = pulses + 1;
      last_pulse_win   = bus.win;
      last_pulse_score = 32'(bus.score);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int lo, input int hi);
    bus.btn_n = 1'b0;
    tick(lo);
    bus.btn_n = 1'b1;
    tick(hi);
  endtask

  task automatic do_reset();
    bus.btn_n = 1'b1;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    bus.btn_n   = 1'b1;
    bus.target  = 5'd10;
    bus.time_up = 1'b0;
    tick(3);
    chk("rst_score",   32'(bus.score), 32'd0);
    chk("rst_hit",     32'(bus.hit_pulse), 32'd0);
    chk("rst_win",     32'(bus.win), 32'd0);
    chk("rst_lose",    32'(bus.lose), 32'd0);
    chk("rst_playing", 32'(bus.playing), 32'd1);

    // 1: button held from release of reset; single pulse at cycle 7.
    rst = 1'b1;
    bus.btn_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("t1_hit_c%0d", k), 32'(bus.hit_pulse), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) chk("t1_score_c7", 32'(bus.score), 32'd1);
    end
    chk("t1_score_held", 32'(bus.score), 32'd1);
    bus.btn_n = 1'b1;
    tick(8);

    // 2: glitches rejected, then ten clean presses win at target 10.
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 4; k++) press(3, 3);
    tick(6);
    chk("t2_glitch_pulses", 32'(pulses - p0), 32'd0);
    chk("t2_glitch_score",  32'(bus.score), 32'd0);
    for (int k = 0; k < 9; k++) press(5, 5);
    chk("t2_score9", 32'(bus.score), 32'd9);
    chk("t2_win9",   32'(bus.win), 32'd0);
    press(5, 5);
    chk("t2_pulses",       32'(pulses - p0), 32'd10);
    chk("t2_pulse10_win",  32'(last_pulse_win), 32'd1);
    chk("t2_pulse10_score", last_pulse_score, 32'd10);
    chk("t2_win",     32'(bus.win), 32'd1);
    chk("t2_lose",    32'(bus.lose), 32'd0);
    chk("t2_playing", 32'(bus.playing), 32'd0);

    // 3: timeout at 4/15 loses 3 cycles later, score then frozen.
    bus.target = 5'd15;
    do_reset();
    for (int k = 0; k < 4; k++) press(5, 5);
    tick(2);
    bus.time_up = 1'b1;
    tick(2);
    chk("t3_lose_c2", 32'(bus.lose), 32'd0);
    tick(1);
    chk("t3_lose_c3", 32'(bus.lose), 32'd1);
    chk("t3_win",     32'(bus.win), 32'd0);
    chk("t3_score",   32'(bus.score), 32'd4);
    p0 = pulses;
    for (int k = 0; k < 2; k++) press(5, 5);
    chk("t3_frozen_score",  32'(bus.score), 32'd4);
    chk("t3_frozen_pulses", 32'(pulses - p0), 32'd0);

    // 4: tenth press lands in the same cycle ts rises; press wins.
    bus.time_up = 1'b0;
    bus.target  = 5'd10;
    do_reset();
    for (int k = 0; k < 9; k++) press(5, 5);
    chk("t4_score9", 32'(bus.score), 32'd9);
    bus.btn_n = 1'b0;
    tick(4);
    bus.time_up = 1'b1;
    tick(2);
    chk("t4_pre_win",  32'(bus.win), 32'd0);
    chk("t4_pre_lose", 32'(bus.lose), 32'd0);
    tick(1);
    chk("t4_hit",   32'(bus.hit_pulse), 32'd1);
    chk("t4_win",   32'(bus.win), 32'd1);
    chk("t4_lose",  32'(bus.lose), 32'd0);
    chk("t4_score", 32'(bus.score), 32'd10);
    bus.btn_n = 1'b1;

    // Countdown already expired at reset release loses after sync latency.
    bus.target = 5'd10;
    do_reset();
    tick(2);
    chk("ts_early_lose", 32'(bus.lose), 32'd0);
    tick(1);
    chk("ts_lose", 32'(bus.lose), 32'd1);
    bus.time_up = 1'b0;

    // target=0 wins on the first clock.
    bus.target = 5'd0;
    do_reset();
    tick(1);
    chk("t0_win", 32'(bus.win), 32'd1);

    // 5: lowering the target mid-game wins next edge; async reset aborts.
    bus.target = 5'd20;
    do_reset();
    for (int k = 0; k < 12; k++) press(5, 5);
    chk("t5_score12", 32'(bus.score), 32'd12);
    chk("t5_win_pre", 32'(bus.win), 32'd0);
    bus.target = 5'd10;
    tick(1);
    chk("t5_win", 32'(bus.win), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_score",   32'(bus.score), 32'd0);
    chk("t5_async_win",     32'(bus.win), 32'd0);
    chk("t5_async_playing", 32'(bus.playing), 32'd1);
    tick(1);

    // 6: target 31 with 33 presses: stops at 31, no wrap.
    bus.target = 5'd31;
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 30; k++) press(5, 5);
    chk("t6_score30", 32'(bus.score), 32'd30);
    chk("t6_win30",   32'(bus.win), 32'd0);
    for (int k = 0; k < 3; k++) press(5, 5);
    chk("t6_score",  32'(bus.score), 32'd31);
    chk("t6_win",    32'(bus.win), 32'd1);
    chk("t6_pulses", 32'(pulses - p0), 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
